// File: rtl/code_seq_pkg.sv
// -----------------------------------------------------------------------------
// code_seq_pkg
// Shared definitions for the character-code sequencer and its consumers
// (decoder_7seg imports CODE_W from here as well).
//   state_t   : FSM state encoding reported on code_sequencer.state
//   CODE_W    : width of the character code
//   next_code : one up/down step of the code, wrapping modulo 2**CODE_W
// -----------------------------------------------------------------------------
package code_seq_pkg;

  localparam int CODE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  // dir=0 counts up, dir=1 counts down; natural overflow gives the wrap.
  function automatic logic [CODE_W-1:0] next_code(input logic [CODE_W-1:0] cur,
                                                  input logic              down);
    logic [CODE_W-1:0] res;
    if (down) res = cur - 1'b1;
    else      res = cur + 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// -----------------------------------------------------------------------------
// btn_sync_edge
// Brings a raw asynchronous pushbutton into the clk domain through a 2-flop
// synchroniser and produces a single-cycle pulse on each synchronised rise.
// Holding the button high yields exactly one pulse.
// Ports:
//   clk      in   system clock, rising edge
//   resetn   in   asynchronous active-low reset (all flops cleared)
//   async_in in   raw active-high button level
//   pulse    out  one-cycle high on a synchronised 0->1 transition
// -----------------------------------------------------------------------------
module btn_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic async_in,
  output logic pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= async_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Combinational from registered terms: a button first sampled at edge N
  // raises the pulse after edge N+1, so the consumer acts at edge N+2.
  assign pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/code_sequencer.sv
// -----------------------------------------------------------------------------
// code_sequencer
// Generates the 2-bit character code for decoder_7seg. In RUN the code steps
// once every DIV_MAX+1 clocks; while paused it steps once per button press.
// Direction is sampled at each step. All outputs are registered.
// Parameters:
//   DIV_WIDTH  width of the prescaler counter
//   DIV_MAX    prescaler terminal count (must be < 2**DIV_WIDTH; 0 = every clock)
// Ports:
//   clk       in   system clock, rising edge
//   resetn    in   asynchronous active-low reset
//   run_sw    in   1 = auto-step, 0 = pause (synchronous level)
//   step_btn  in   raw asynchronous pushbutton, single step while paused
//   dir       in   0 = up, 1 = down (synchronous)
//   code      out  character code
//   tick      out  high in the first cycle code shows a new value
//   state     out  FSM state: 00 IDLE, 01 RUN, 10 PAUSE
// -----------------------------------------------------------------------------
module code_sequencer
  import code_seq_pkg::*;
#(
  parameter int DIV_WIDTH = 26,
  parameter int DIV_MAX   = 49999999
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run_sw,
  input  logic              step_btn,
  input  logic              dir,
  output logic [CODE_W-1:0] code,
  output logic              tick,
  output logic [1:0]        state
);

  localparam logic [DIV_WIDTH-1:0] LP_DIV_MAX = DIV_WIDTH'(DIV_MAX);

  state_t              r_state;
  state_t              w_state_next;
  logic [DIV_WIDTH-1:0] r_presc;
  logic [DIV_WIDTH-1:0] w_presc_next;
  logic [CODE_W-1:0]   r_code;
  logic [CODE_W-1:0]   w_code_next;
  logic                r_tick;
  logic                w_do_step;
  logic                w_step_edge;

  btn_sync_edge u_btn (
    .clk      (clk),
    .resetn   (resetn),
    .async_in (step_btn),
    .pulse    (w_step_edge)
  );

  // Prescaler defaults to 0 so every path out of RUN, and every non-RUN
  // state, leaves it cleared; only RUN advances it.
  always_comb begin
    w_state_next = r_state;
    w_presc_next = '0;
    w_do_step    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // run_sw has priority: a coincident button pulse is dropped.
        if (run_sw) begin
          w_state_next = ST_RUN;
        end else if (w_step_edge) begin
          w_state_next = ST_PAUSE;
          w_do_step    = 1'b1;
        end
      end
      ST_RUN: begin
        // Leaving RUN never steps, even on the terminal count.
        if (!run_sw) begin
          w_state_next = ST_PAUSE;
        end else if (r_presc == LP_DIV_MAX) begin
          w_do_step = 1'b1;
        end else begin
          w_presc_next = r_presc + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (run_sw) begin
          w_state_next = ST_RUN;
        end else if (w_step_edge) begin
          w_do_step = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign w_code_next = w_do_step ? next_code(r_code, dir) : r_code;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
      r_code  <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_presc <= w_presc_next;
      r_code  <= w_code_next;
      r_tick  <= w_do_step;
    end
  end

  assign code  = r_code;
  assign tick  = r_tick;
  assign state = r_state;

endmodule
